button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
- Memory-mapped button input controller between the raw board button pins and the SoC memory bus.
- Replaces direct raw button reads with three stages: a two-flop synchronizer, a per-button programmable debounce filter, and sticky rising/falling edge flags.
- Flags are write-1-to-clear; an aggregate interrupt line is provided.
- Occupies a 16-byte slot at 0x00010020; its read value and ready are OR-combined onto the shared bus like the other peripherals.

Parameters:
- COUNT, 4, number of button inputs (1..32).
- CNT_WIDTH, 20, width of the debounce counters and of the CFG threshold field.
- DEBOUNCE_DEFAULT, 36000, reset value of the threshold (1 ms at 36 MHz).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- buttons_in  input  COUNT  raw asynchronous button levels.
- address_in  input  32  bus address; only bits [3:2] are decoded.
- sel_in  input  1  slot select from the top-level decoder.
- read_in  input  1  read strobe; no side effects, informational only.
- read_value_out  output  32  read data; must be 0 when sel_in=0.
- write_mask_in  input  4  byte write enables.
- write_value_in  input  32  write data.
- ready_out  output  1  equals sel_in (single-cycle access).
- irq_out  output  1  registered; high while any RISE or FALL flag is set.

Behaviour:
- Reset (reset=0, asynchronous):
  - sync flops, stable, RISE, FALL, all counters and irq_out go to 0.
  - CFG goes to DEBOUNCE_DEFAULT.
  - Reset mid-debounce discards any count in progress.
- Register map, offset = address_in[3:2]:
  - 0 STATE (RO): {0, stable[COUNT-1:0]}.
  - 1 RISE (W1C).
  - 2 FALL (W1C).
  - 3 CFG (RW): threshold in [CNT_WIDTH-1:0]; upper bits read 0.
- Reads are combinational: read_value_out = sel_in ? reg : 0.
- Writes: take effect at posedge clk when sel_in=1, per byte lane of write_mask_in.
  - Writes to STATE are ignored.
  - RISE/FALL: each bit with a 1 in an enabled lane is cleared.
  - CFG: enabled lanes are updated; any CFG write also clears all debounce counters.
- Synchronizer: two flops per bit. sync reflects a settled input change after the second edge.
- Debounce, per bit i, each posedge, with threshold N = (CFG==0) ? 1 : CFG:
  - sync[i]==stable[i]: cnt[i] <= 0.
  - sync[i]!=stable[i] and cnt[i]==N-1: stable[i] <= sync[i], cnt[i] <= 0, set RISE[i] if the new value is 1, else FALL[i].
  - Otherwise: cnt[i] <= cnt[i]+1.
  - Counters never wrap: cnt < N always holds, and a CFG write clears the counters.
- Latency: an input settled before posedge k makes stable change visible after posedge k+N+1. A glitch shorter than N cycles at the sync output produces no change and no flag.
- Simultaneous events:
  - Flag set and W1C of the same bit in the same cycle: set wins, flag stays 1.
  - Rise and fall on different bits in the same cycle: both flags set.
- irq_out <= |(RISE|FALL) next-state, i.e. registered and aligned with the flag update.
- Bits at or above COUNT in any register read as 0 and ignore writes.

Test Plan:
- Reset with buttons_in=4'b0101: STATE=0, RISE=0, FALL=0, CFG=36000, irq_out=0.
- CFG=4, set buttons_in[0]=1 before edge k: STATE reads 0x1 after edge k+5, not before; RISE=0x1; irq_out=1 from the same edge.
- CFG=4, 3-cycle pulse on buttons_in[2]: STATE, RISE and FALL stay 0, irq_out stays 0.
- With RISE=0x1, write RISE=0x1 (mask 4'b0001): RISE=0 and irq_out=0 next cycle. Repeat with a new rise on bit 0 completing in the same cycle: RISE stays 0x1.
- CFG=0, toggle buttons_in[1] 0→1→0 with 3-cycle spacing: rise then fall each pass at latency 2; RISE=0x2 and FALL=0x2.
- Bus: sel_in=0 with any address gives read_value_out=0 and ready_out=0. sel_in=1 at 0x0001002C reads CFG. A byte-0 write of 0xFF to CFG=0x00012345 yields 0x000123FF.

Source files
------------

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Purpose  : Memory-mapped button input controller. Each raw button passes
//            through a two-flop synchronizer and a programmable debounce
//            filter. Sticky, write-1-to-clear RISE/FALL flags record the
//            debounced edges and drive an aggregate interrupt.
// Ports    : clk            - system clock
//            reset          - asynchronous, active-low reset
//            buttons_in     - raw asynchronous button levels
//            address_in     - bus address, bits [3:2] select the register
//            sel_in         - slot select
//            read_in        - read strobe (no side effects)
//            read_value_out - read data, 0 when not selected
//            write_mask_in  - byte write enables
//            write_value_in - write data
//            ready_out      - single-cycle ready (equals sel_in)
//            irq_out        - high while any RISE or FALL flag is set
// Registers: 0 STATE (RO), 1 RISE (W1C), 2 FALL (W1C), 3 CFG (RW threshold)
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int COUNT            = 4,
    parameter int CNT_WIDTH        = 20,
    parameter int DEBOUNCE_DEFAULT = 36000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [COUNT-1:0] buttons_in,
    input  logic [31:0]      address_in,
    input  logic             sel_in,
    input  logic             read_in,
    output logic [31:0]      read_value_out,
    input  logic [3:0]       write_mask_in,
    input  logic [31:0]      write_value_in,
    output logic             ready_out,
    output logic             irq_out
);

    localparam logic [1:0] OFF_STATE = 2'd0;
    localparam logic [1:0] OFF_RISE  = 2'd1;
    localparam logic [1:0] OFF_FALL  = 2'd2;
    localparam logic [1:0] OFF_CFG   = 2'd3;

    logic [COUNT-1:0]     sync1_q, sync2_q;
    logic [COUNT-1:0]     stable_q, stable_d;
    logic [COUNT-1:0]     rise_q, rise_d;
    logic [COUNT-1:0]     fall_q, fall_d;
    logic [CNT_WIDTH-1:0] cnt_q [COUNT];
    logic [CNT_WIDTH-1:0] cnt_d [COUNT];
    logic [CNT_WIDTH-1:0] cfg_q, cfg_d;
    logic                 irq_q;

    logic [1:0]           w_off;
    logic [31:0]          w_mask32;
    logic                 w_wr_rise, w_wr_fall, w_wr_cfg;
    logic [COUNT-1:0]     w_clr;
    logic [CNT_WIDTH-1:0] w_limit;
    logic [COUNT-1:0]     w_set_rise, w_set_fall;
    logic [31:0]          w_rdata;
    logic                 w_unused_bits;

    assign w_off    = address_in[3:2];
    assign w_mask32 = {{8{write_mask_in[3]}}, {8{write_mask_in[2]}},
                       {8{write_mask_in[1]}}, {8{write_mask_in[0]}}};

    assign w_wr_rise = sel_in && (w_off == OFF_RISE);
    assign w_wr_fall = sel_in && (w_off == OFF_FALL);
    assign w_wr_cfg  = sel_in && (w_off == OFF_CFG) && (|write_mask_in);

    // Bits written with 1 in an enabled lane; only implemented bits exist.
    assign w_clr = write_value_in[COUNT-1:0] & w_mask32[COUNT-1:0];

    // Terminal count is N-1 where a threshold of 0 behaves as 1.
    assign w_limit = (cfg_q == '0) ? '0 : cfg_q - 1'b1;

    // Debounce filter: a bit commits once the synchronized level has
    // differed from the stable level for N consecutive cycles.
    always_comb begin
        stable_d   = stable_q;
        w_set_rise = '0;
        w_set_fall = '0;
        for (int i = 0; i < COUNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == w_limit) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
                if (sync2_q[i]) begin
                    w_set_rise[i] = 1'b1;
                end else begin
                    w_set_fall[i] = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
            // A new threshold restarts every filter so cnt < N still holds.
            if (w_wr_cfg) begin
                cnt_d[i] = '0;
            end
        end
    end

    // Setting has priority over a simultaneous clear of the same flag.
    assign rise_d = (rise_q & ~(w_wr_rise ? w_clr : '0)) | w_set_rise;
    assign fall_d = (fall_q & ~(w_wr_fall ? w_clr : '0)) | w_set_fall;

    assign cfg_d = w_wr_cfg
                 ? ((cfg_q & ~w_mask32[CNT_WIDTH-1:0]) |
                    (write_value_in[CNT_WIDTH-1:0] & w_mask32[CNT_WIDTH-1:0]))
                 : cfg_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            cfg_q    <= CNT_WIDTH'(DEBOUNCE_DEFAULT);
            irq_q    <= 1'b0;
            for (int i = 0; i < COUNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= buttons_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            cfg_q    <= cfg_d;
            irq_q    <= |(rise_d | fall_d);
            for (int i = 0; i < COUNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_STATE: w_rdata[COUNT-1:0]     = stable_q;
            OFF_RISE:  w_rdata[COUNT-1:0]     = rise_q;
            OFF_FALL:  w_rdata[COUNT-1:0]     = fall_q;
            OFF_CFG:   w_rdata[CNT_WIDTH-1:0] = cfg_q;
            default:   w_rdata = '0;
        endcase
    end

    assign read_value_out = sel_in ? w_rdata : 32'h0;
    assign ready_out      = sel_in;
    assign irq_out        = irq_q;

    // Inputs that carry no function in this slot.
    assign w_unused_bits = ^{read_in, address_in, write_value_in, w_mask32};

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debounce
// Purpose  : Self-checking bench for button_debounce. Expected values are
//            queued when a check is issued and popped when the DUT output
//            is sampled. Bus decode is covered by a vector table; latency,
//            glitch rejection and flag priority by directed sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

    localparam int COUNT = 4;
    localparam logic [31:0] BASE = 32'h0001_0020;

    logic             clk;
    logic             reset;
    logic [COUNT-1:0] buttons_in;
    logic [31:0]      address_in;
    logic             sel_in;
    logic             read_in;
    logic [31:0]      read_value_out;
    logic [3:0]       write_mask_in;
    logic [31:0]      write_value_in;
    logic             ready_out;
    logic             irq_out;

    button_debounce #(
        .COUNT(COUNT),
        .CNT_WIDTH(20),
        .DEBOUNCE_DEFAULT(36000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .buttons_in(buttons_in),
        .address_in(address_in),
        .sel_in(sel_in),
        .read_in(read_in),
        .read_value_out(read_value_out),
        .write_mask_in(write_mask_in),
        .write_value_in(write_value_in),
        .ready_out(ready_out),
        .irq_out(irq_out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic [31:0] exp_rd;
        logic        exp_rdy;
    } bus_vec_t;

    bus_vec_t    tbl [8];
    logic [31:0] sb_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic compare(input string nm, input logic [31:0] act);
        logic [31:0] exp;
        exp = sb_q.pop_front();
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] off, input logic [31:0] exp);
        sel_in        = 1'b1;
        address_in    = BASE | {28'h0, off, 2'b00};
        write_mask_in = 4'h0;
        sb_q.push_back(exp);
        #1;
        compare(nm, read_value_out);
        sel_in     = 1'b0;
        address_in = 32'h0;
    endtask

    task automatic irq_chk(input string nm, input logic exp);
        sb_q.push_back({31'h0, exp});
        compare(nm, {31'h0, irq_out});
    endtask

    // Called after a falling edge; the write lands on the next rising edge.
    task automatic bus_write(input logic [1:0] off, input logic [31:0] d, input logic [3:0] m);
        sel_in         = 1'b1;
        address_in     = BASE | {28'h0, off, 2'b00};
        write_mask_in  = m;
        write_value_in = d;
        step();
        sel_in         = 1'b0;
        address_in     = 32'h0;
        write_mask_in  = 4'h0;
        write_value_in = 32'h0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b0;
        buttons_in     = 4'b0101;
        address_in     = 32'h0;
        sel_in         = 1'b0;
        read_in        = 1'b0;
        write_mask_in  = 4'h0;
        write_value_in = 32'h0;

        // Reset state, held across several clocks with buttons active.
        repeat (3) @(negedge clk);
        #1;
        rd_chk("reset_state", 2'd0, 32'h0);
        rd_chk("reset_rise",  2'd1, 32'h0);
        rd_chk("reset_fall",  2'd2, 32'h0);
        rd_chk("reset_cfg",   2'd3, 32'd36000);
        irq_chk("reset_irq", 1'b0);
        buttons_in = 4'b0000;
        @(negedge clk);
        reset = 1'b1;

        bus_write(2'd3, 32'd4, 4'hF);

        // Glitch of 3 cycles with N=4 must be rejected.
        buttons_in[2] = 1'b1;
        repeat (3) step();
        buttons_in[2] = 1'b0;
        repeat (8) step();
        rd_chk("glitch_state", 2'd0, 32'h0);
        rd_chk("glitch_rise",  2'd1, 32'h0);
        rd_chk("glitch_fall",  2'd2, 32'h0);
        irq_chk("glitch_irq", 1'b0);

        // Rise on bit 0 with N=4: visible after edge k+5 only.
        buttons_in[0] = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            step();
            rd_chk($sformatf("rise_lat_state_k%0d", i), 2'd0, (i == 5) ? 32'h1 : 32'h0);
            irq_chk($sformatf("rise_lat_irq_k%0d", i), (i == 5));
        end
        rd_chk("rise_flag", 2'd1, 32'h1);
        rd_chk("rise_nofall", 2'd2, 32'h0);

        // W1C of RISE.
        bus_write(2'd1, 32'h1, 4'b0001);
        rd_chk("w1c_rise", 2'd1, 32'h0);
        irq_chk("w1c_irq", 1'b0);

        // Fall on bit 0, then clear it.
        buttons_in[0] = 1'b0;
        repeat (6) step();
        rd_chk("fall_flag", 2'd2, 32'h1);
        bus_write(2'd2, 32'h1, 4'b0001);

        // New rise completes on the same edge as a W1C: set wins.
        buttons_in[0] = 1'b1;
        repeat (5) step();
        rd_chk("collide_pre", 2'd0, 32'h0);
        bus_write(2'd1, 32'h1, 4'b0001);
        rd_chk("collide_rise",  2'd1, 32'h1);
        rd_chk("collide_state", 2'd0, 32'h1);
        irq_chk("collide_irq", 1'b1);

        // Clear everything, then CFG=0 behaves as N=1 (latency 2).
        bus_write(2'd1, 32'hF, 4'hF);
        bus_write(2'd2, 32'hF, 4'hF);
        irq_chk("clear_irq", 1'b0);
        bus_write(2'd3, 32'h0, 4'hF);
        for (int p = 0; p < 2; p++) begin
            buttons_in[1] = 1'b1;
            step();
            step();
            rd_chk($sformatf("n1_rise_pre_p%0d", p), 2'd0, 32'h1);
            step();
            rd_chk($sformatf("n1_rise_p%0d", p), 2'd0, 32'h3);
            buttons_in[1] = 1'b0;
            step();
            step();
            rd_chk($sformatf("n1_fall_pre_p%0d", p), 2'd0, 32'h3);
            step();
            rd_chk($sformatf("n1_fall_p%0d", p), 2'd0, 32'h1);
            step();
        end
        rd_chk("n1_rise_flags", 2'd1, 32'h2);
        rd_chk("n1_fall_flags", 2'd2, 32'h2);

        // Byte-lane CFG writes, STATE write ignored, unimplemented bits.
        bus_write(2'd3, 32'h0001_2345, 4'hF);
        rd_chk("cfg_full", 2'd3, 32'h0001_2345);
        bus_write(2'd3, 32'h0000_00FF, 4'b0001);
        rd_chk("cfg_byte0", 2'd3, 32'h0001_23FF);
        bus_write(2'd0, 32'hFFFF_FFFF, 4'hF);
        rd_chk("state_ro", 2'd0, 32'h1);
        bus_write(2'd1, 32'hFFFF_FFF0, 4'hF);
        rd_chk("rise_hibits", 2'd1, 32'h2);

        // Bus decode table.
        tbl[0] = '{1'b1, 32'h0001_0020, 32'h0000_0001, 1'b1};
        tbl[1] = '{1'b1, 32'h0001_0024, 32'h0000_0002, 1'b1};
        tbl[2] = '{1'b1, 32'h0001_0028, 32'h0000_0002, 1'b1};
        tbl[3] = '{1'b1, 32'h0001_002C, 32'h0001_23FF, 1'b1};
        tbl[4] = '{1'b0, 32'h0001_0020, 32'h0000_0000, 1'b0};
        tbl[5] = '{1'b0, 32'h0001_002C, 32'h0000_0000, 1'b0};
        tbl[6] = '{1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tbl[7] = '{1'b1, 32'h0001_003C, 32'h0001_23FF, 1'b1};
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            sel_in     = tbl[v].sel;
            address_in = tbl[v].addr;
            sb_q.push_back(tbl[v].exp_rd);
            sb_q.push_back({31'h0, tbl[v].exp_rdy});
            #1;
            compare($sformatf("tbl%0d_rdata", v), read_value_out);
            compare($sformatf("tbl%0d_ready", v), {31'h0, ready_out});
            sel_in     = 1'b0;
            address_in = 32'h0;
        end

        @(negedge clk);
        bus_write(2'd3, 32'hFFFF_FFFF, 4'hF);
        rd_chk("cfg_upper_zero", 2'd3, 32'h000F_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
